fofb_readout_tracker: RTL and testbench
=======================================

// Module: fofb_readout_tracker
// PURPOSE
//  sysClk-domain readout tracker for N cell-link status streams. Once per FA cycle it gathers
//  status records, builds the all-cells and FOFB-enabled bitmaps and counts distinct cells.
//  It closes the readout on completion or on a programmable microsecond timeout, and keeps
//  per-link error counts. Sits between the link status mux and the FOFB DSP readout.
// PARAMETERS
//  SYSCLK_RATE      100000000            sysClk frequency, Hz
//  NUM_LINKS        2                    number of status streams handled in parallel
//  MAX_CELLS        32                   bitmap width
//  CELL_INDEX_WIDTH $clog2(MAX_CELLS)    cell index width
//  CELL_COUNT_WIDTH $clog2(MAX_CELLS+1)  cell count width
//  TIMER_WIDTH      8                    readout timer / timeout width, microseconds
//  SEQNO_WIDTH      3                    completed-readout sequence number width
//  ERR_COUNT_WIDTH  8                    per-link saturating error counter width
// PORTS
//  sysClk             in   1                          system clock
//  sysReset           in   1                          asynchronous, active-high reset
//  cfgWrite           in   1                          latch cfgCellCount/cfgTimeoutUs into shadow registers
//  cfgCellCount       in   CELL_COUNT_WIDTH           expected cell count
//  cfgTimeoutUs       in   TIMER_WIDTH                timeout in us; 0 disables the timeout
//  errCountClear      in   1                          clear all link error counters
//  FAstrobe           in   1                          start of FA cycle
//  statusValid        in   NUM_LINKS                  per-link status record strobe
//  statusCellIndex    in   NUM_LINKS*CELL_INDEX_WIDTH link i at [i*CELL_INDEX_WIDTH+:CELL_INDEX_WIDTH]
//  statusCode         in   NUM_LINKS*2                2'd0 = success; any other value = error
//  statusFOFBenabled  in   NUM_LINKS                  sending cell has FOFB enabled
//  readoutActive      out  1                          collection window open
//  readoutValid       out  1                          all expected cells received
//  readTimeout        out  1                          window closed by timeout
//  timeoutStrobe      out  1                          one-cycle pulse when a timeout closes the window
//  fofbEnabled        out  1                          every expected cell reported FOFB enabled
//  fofbBitmapAll      out  MAX_CELLS                  cells received in this cycle
//  fofbBitmapEnabled  out  MAX_CELLS                  FOFB-enabled cells received
//  bitmapAllSnapshot  out  MAX_CELLS                  fofbBitmapAll captured at FAstrobe
//  bitmapEnSnapshot   out  MAX_CELLS                  fofbBitmapEnabled captured at FAstrobe
//  readoutTime        out  TIMER_WIDTH                us elapsed when the window closed
//  seqno              out  SEQNO_WIDTH                incremented on each valid completion
//  linkErrorCount     out  NUM_LINKS*ERR_COUNT_WIDTH  per-link error counts
// BEHAVIOUR
//  - Reset: every output 0; the shadow config registers are also 0.
//  - cfgWrite: updates the pending config at any time. The pending config is copied to the
//    active config only on FAstrobe, so it never changes mid-window.
//  - FAstrobe (highest priority): snapshots <= current bitmaps; bitmaps and counters cleared;
//    readoutActive=1; readoutValid=0; readTimeout=0; timer=0; us divider = SYSCLK_RATE/1e6-1.
//    Status records arriving in the same cycle are dropped.
//  - While active, a record is accepted on link i when valid, code==0 and
//    index < active cellCount. Accepted records set fofbBitmapAll[idx]; with FOFBenabled
//    they also set fofbBitmapEnabled[idx].
//  - cellCounter += number of distinct indices newly set this cycle. Duplicates across links
//    in the same cycle, or indices already set, count once. fofbCounter follows the same rule.
//  - Error: a record with valid and (code!=0 or index>=cellCount) increments linkErrorCount[i].
//    Counters saturate at all-ones and count in any state. errCountClear wins over an increment.
//  - Completion: registered cellCounter == cellCount sets readoutValid=1 and
//    fofbEnabled = (fofbCounter==cellCount). It also sets readoutTime=timer, seqno+=1,
//    readoutActive=0. Latency is 1 cycle after the last bitmap update.
//    cellCount==0 completes on the first cycle after FAstrobe.
//  - Timer: the divider reaching 0 increments the timer. The timer saturates at all-ones.
//  - Timeout: cfgTimeoutUs!=0 and timer>=cfgTimeoutUs. Sets readTimeout=1, fofbEnabled=0,
//    readoutTime=timer, readoutActive=0, and pulses timeoutStrobe for 1 cycle.
//    Completion has priority if both occur in the same cycle.
//  - Idle (not active): status records do not touch the bitmaps; bitmaps hold until the next
//    FAstrobe.
//  - seqno wraps modulo 2^SEQNO_WIDTH.
//  - sysReset mid-window: everything returns to reset values immediately; the next FAstrobe
//    restarts cleanly.
// CONFIGURATION
//  FOFB_TRACKER_LATE_COUNT_EN defined:
//   - extra output lateCount [15:0], saturating.
//   - counts successful records received while readoutActive=0, or in the FAstrobe cycle.
//   - cleared by errCountClear.
//  Undefined: no port; late records are silently ignored.
// TESTING
//  1. cellCount=4, links deliver cells 0..3 over 4 cycles, all enabled -> readoutValid=1
//     1 cycle after the 4th; fofbEnabled=1; seqno 0->1.
//  2. Same cycle: link0 idx 2 and link1 idx 2 -> cellCounter +1 only; bitmap=0x4.
//  3. cfgTimeoutUs=5, cellCount=3, only 2 cells sent -> readTimeout=1 at 5 us;
//     timeoutStrobe is one pulse; readoutTime=5; fofbEnabled=0.
//  4. code=2 on link1 x300, then index 7 with cellCount=4 -> linkErrorCount[1]=255
//     (saturated); bitmap unchanged.
//  5. cfgWrite cellCount=2 mid-window -> the window still uses the old count;
//     the next FA cycle completes after 2 cells.
//  6. sysReset asserted mid-window -> all outputs 0; FAstrobe then restarts normally.
//     With the macro enabled: a record after completion -> lateCount=1.

Source files
------------

// File: rtl/fofb_readout_tracker_if.sv
// Status-stream bundle from the link status mux into the readout tracker.
interface fofb_readout_tracker_if #(
    parameter int unsigned NUM_LINKS        = 2,
    parameter int unsigned CELL_INDEX_WIDTH = 5
);
    logic                                  FAstrobe;
    logic [NUM_LINKS-1:0]                  statusValid;
    logic [NUM_LINKS*CELL_INDEX_WIDTH-1:0] statusCellIndex;
    logic [NUM_LINKS*2-1:0]                statusCode;
    logic [NUM_LINKS-1:0]                  statusFOFBenabled;

    modport master (
        output FAstrobe, statusValid, statusCellIndex, statusCode, statusFOFBenabled
    );

    modport slave (
        input  FAstrobe, statusValid, statusCellIndex, statusCode, statusFOFBenabled
    );
endinterface

// File: rtl/fofb_readout_tracker.sv
// Per-FA-cycle readout tracker: cell bitmaps, distinct-cell counts, us timeout, link error counts.
// Optional FOFB_TRACKER_LATE_COUNT_EN adds a saturating lateCount of out-of-window successes.
module fofb_readout_tracker #(
    parameter int unsigned SYSCLK_RATE      = 100000000,
    parameter int unsigned NUM_LINKS        = 2,
    parameter int unsigned MAX_CELLS        = 32,
    parameter int unsigned CELL_INDEX_WIDTH = $clog2(MAX_CELLS),
    parameter int unsigned CELL_COUNT_WIDTH = $clog2(MAX_CELLS + 1),
    parameter int unsigned TIMER_WIDTH      = 8,
    parameter int unsigned SEQNO_WIDTH      = 3,
    parameter int unsigned ERR_COUNT_WIDTH  = 8
) (
    input  logic                                 sysClk,
    input  logic                                 sysReset,
    fofb_readout_tracker_if.slave                statusBus,
    input  logic                                 cfgWrite,
    input  logic [CELL_COUNT_WIDTH-1:0]          cfgCellCount,
    input  logic [TIMER_WIDTH-1:0]               cfgTimeoutUs,
    input  logic                                 errCountClear,
    output logic                                 readoutActive,
    output logic                                 readoutValid,
    output logic                                 readTimeout,
    output logic                                 timeoutStrobe,
    output logic                                 fofbEnabled,
    output logic [MAX_CELLS-1:0]                 fofbBitmapAll,
    output logic [MAX_CELLS-1:0]                 fofbBitmapEnabled,
    output logic [MAX_CELLS-1:0]                 bitmapAllSnapshot,
    output logic [MAX_CELLS-1:0]                 bitmapEnSnapshot,
    output logic [TIMER_WIDTH-1:0]               readoutTime,
    output logic [SEQNO_WIDTH-1:0]               seqno,
    output logic [NUM_LINKS*ERR_COUNT_WIDTH-1:0] linkErrorCount
`ifdef FOFB_TRACKER_LATE_COUNT_EN
    ,
    output logic [15:0]                          lateCount
`endif
);

    localparam int unsigned DIV_RELOAD   = SYSCLK_RATE / 1000000 - 1;
    localparam int unsigned DIV_WIDTH    = ($clog2(DIV_RELOAD + 1) > 0) ? $clog2(DIV_RELOAD + 1) : 1;
    localparam int unsigned LINK_CNT_W   = $clog2(NUM_LINKS + 1);

    typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

    state_t                      state;
    logic [CELL_COUNT_WIDTH-1:0] pendCellCount;
    logic [TIMER_WIDTH-1:0]      pendTimeoutUs;
    logic [CELL_COUNT_WIDTH-1:0] activeCellCount;
    logic [TIMER_WIDTH-1:0]      activeTimeoutUs;
    logic [CELL_COUNT_WIDTH-1:0] cellCounter;
    logic [CELL_COUNT_WIDTH-1:0] fofbCounter;
    logic [TIMER_WIDTH-1:0]      timer;
    logic [DIV_WIDTH-1:0]        usDivider;

    logic [MAX_CELLS-1:0]        acceptAll;
    logic [MAX_CELLS-1:0]        acceptEn;
    logic [MAX_CELLS-1:0]        newAll;
    logic [MAX_CELLS-1:0]        newEn;
    logic [NUM_LINKS-1:0]        errHit;
    logic [NUM_LINKS-1:0]        successHit;
    logic [CELL_COUNT_WIDTH-1:0] newAllCount;
    logic [CELL_COUNT_WIDTH-1:0] newEnCount;
    logic [LINK_CNT_W-1:0]       successCount;

    function automatic logic [CELL_COUNT_WIDTH-1:0] popCells(input logic [MAX_CELLS-1:0] v);
        logic [CELL_COUNT_WIDTH-1:0] sum;
        sum = '0;
        for (int b = 0; b < int'(MAX_CELLS); b++) begin
            sum = sum + CELL_COUNT_WIDTH'(v[b]);
        end
        return sum;
    endfunction

    // Classify each link's record; only cells not yet in the bitmap count as new.
    always_comb begin
        acceptAll    = '0;
        acceptEn     = '0;
        errHit       = '0;
        successHit   = '0;
        successCount = '0;
        for (int i = 0; i < int'(NUM_LINKS); i++) begin
            logic [CELL_INDEX_WIDTH-1:0] idx;
            logic                        codeOk;
            logic                        inRange;
            idx     = statusBus.statusCellIndex[i*CELL_INDEX_WIDTH +: CELL_INDEX_WIDTH];
            codeOk  = (statusBus.statusCode[i*2 +: 2] == 2'd0);
            inRange = (CELL_COUNT_WIDTH'(idx) < activeCellCount);
            if (statusBus.statusValid[i] && codeOk && inRange) begin
                acceptAll[idx] = 1'b1;
                if (statusBus.statusFOFBenabled[i]) begin
                    acceptEn[idx] = 1'b1;
                end
            end
            errHit[i]     = statusBus.statusValid[i] && (!codeOk || !inRange);
            successHit[i] = statusBus.statusValid[i] && codeOk;
            successCount  = successCount + LINK_CNT_W'(successHit[i]);
        end
        newAll      = acceptAll & ~fofbBitmapAll;
        newEn       = acceptEn & ~fofbBitmapEnabled;
        newAllCount = popCells(newAll);
        newEnCount  = popCells(newEn);
    end

    // Config shadows, error counters and the readout window state machine.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state             <= ST_IDLE;
            pendCellCount     <= '0;
            pendTimeoutUs     <= '0;
            activeCellCount   <= '0;
            activeTimeoutUs   <= '0;
            cellCounter       <= '0;
            fofbCounter       <= '0;
            timer             <= '0;
            usDivider         <= '0;
            readoutActive     <= 1'b0;
            readoutValid      <= 1'b0;
            readTimeout       <= 1'b0;
            timeoutStrobe     <= 1'b0;
            fofbEnabled       <= 1'b0;
            fofbBitmapAll     <= '0;
            fofbBitmapEnabled <= '0;
            bitmapAllSnapshot <= '0;
            bitmapEnSnapshot  <= '0;
            readoutTime       <= '0;
            seqno             <= '0;
            linkErrorCount    <= '0;
`ifdef FOFB_TRACKER_LATE_COUNT_EN
            lateCount         <= '0;
`endif
        end else begin
            timeoutStrobe <= 1'b0;

            if (cfgWrite) begin
                pendCellCount <= cfgCellCount;
                pendTimeoutUs <= cfgTimeoutUs;
            end

            for (int i = 0; i < int'(NUM_LINKS); i++) begin
                if (errCountClear) begin
                    linkErrorCount[i*ERR_COUNT_WIDTH +: ERR_COUNT_WIDTH] <= '0;
                end else if (errHit[i] &&
                             linkErrorCount[i*ERR_COUNT_WIDTH +: ERR_COUNT_WIDTH] != '1) begin
                    linkErrorCount[i*ERR_COUNT_WIDTH +: ERR_COUNT_WIDTH] <=
                        linkErrorCount[i*ERR_COUNT_WIDTH +: ERR_COUNT_WIDTH] + 1'b1;
                end
            end

`ifdef FOFB_TRACKER_LATE_COUNT_EN
            if (errCountClear) begin
                lateCount <= '0;
            end else if (!readoutActive || statusBus.FAstrobe) begin
                if (17'(lateCount) + 17'(successCount) > 17'hFFFF) begin
                    lateCount <= 16'hFFFF;
                end else begin
                    lateCount <= lateCount + 16'(successCount);
                end
            end
`endif

            if (statusBus.FAstrobe) begin
                activeCellCount   <= pendCellCount;
                activeTimeoutUs   <= pendTimeoutUs;
                bitmapAllSnapshot <= fofbBitmapAll;
                bitmapEnSnapshot  <= fofbBitmapEnabled;
                fofbBitmapAll     <= '0;
                fofbBitmapEnabled <= '0;
                cellCounter       <= '0;
                fofbCounter       <= '0;
                timer             <= '0;
                usDivider         <= DIV_WIDTH'(DIV_RELOAD);
                readoutActive     <= 1'b1;
                readoutValid      <= 1'b0;
                readTimeout       <= 1'b0;
                fofbEnabled       <= 1'b0;
                state             <= ST_ACTIVE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_ACTIVE: begin
                        if (cellCounter == activeCellCount) begin
                            readoutValid  <= 1'b1;
                            fofbEnabled   <= (fofbCounter == activeCellCount);
                            readoutTime   <= timer;
                            seqno         <= seqno + 1'b1;
                            readoutActive <= 1'b0;
                            state         <= ST_IDLE;
                        end else if (activeTimeoutUs != '0 && timer >= activeTimeoutUs) begin
                            readTimeout   <= 1'b1;
                            timeoutStrobe <= 1'b1;
                            fofbEnabled   <= 1'b0;
                            readoutTime   <= timer;
                            readoutActive <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            fofbBitmapAll     <= fofbBitmapAll | acceptAll;
                            fofbBitmapEnabled <= fofbBitmapEnabled | acceptEn;
                            cellCounter       <= cellCounter + newAllCount;
                            fofbCounter       <= fofbCounter + newEnCount;
                            if (usDivider == '0) begin
                                usDivider <= DIV_WIDTH'(DIV_RELOAD);
                                if (timer != '1) begin
                                    timer <= timer + 1'b1;
                                end
                            end else begin
                                usDivider <= usDivider - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fofb_readout_tracker.sv
// Directed self-checking bench for fofb_readout_tracker (2 links, 32 cells, 100 MHz sysClk).
module tb_fofb_readout_tracker;

    localparam int unsigned NL  = 2;
    localparam int unsigned CIW = 5;
    localparam int unsigned CCW = 6;

    logic        sysClk;
    logic        sysReset;
    logic        cfgWrite;
    logic [5:0]  cfgCellCount;
    logic [7:0]  cfgTimeoutUs;
    logic        errCountClear;
    logic        readoutActive;
    logic        readoutValid;
    logic        readTimeout;
    logic        timeoutStrobe;
    logic        fofbEnabled;
    logic [31:0] fofbBitmapAll;
    logic [31:0] fofbBitmapEnabled;
    logic [31:0] bitmapAllSnapshot;
    logic [31:0] bitmapEnSnapshot;
    logic [7:0]  readoutTime;
    logic [2:0]  seqno;
    logic [15:0] linkErrorCount;
`ifdef FOFB_TRACKER_LATE_COUNT_EN
    logic [15:0] lateCount;
`endif

    int checks;
    int errors;
    int n;

    fofb_readout_tracker_if #(.NUM_LINKS(NL), .CELL_INDEX_WIDTH(CIW)) statusBus ();

    fofb_readout_tracker dut (
        .sysClk            (sysClk),
        .sysReset          (sysReset),
        .statusBus         (statusBus.slave),
        .cfgWrite          (cfgWrite),
        .cfgCellCount      (cfgCellCount),
        .cfgTimeoutUs      (cfgTimeoutUs),
        .errCountClear     (errCountClear),
        .readoutActive     (readoutActive),
        .readoutValid      (readoutValid),
        .readTimeout       (readTimeout),
        .timeoutStrobe     (timeoutStrobe),
        .fofbEnabled       (fofbEnabled),
        .fofbBitmapAll     (fofbBitmapAll),
        .fofbBitmapEnabled (fofbBitmapEnabled),
        .bitmapAllSnapshot (bitmapAllSnapshot),
        .bitmapEnSnapshot  (bitmapEnSnapshot),
        .readoutTime       (readoutTime),
        .seqno             (seqno),
        .linkErrorCount    (linkErrorCount)
`ifdef FOFB_TRACKER_LATE_COUNT_EN
        ,
        .lateCount         (lateCount)
`endif
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic clearStatus();
        statusBus.FAstrobe          = 1'b0;
        statusBus.statusValid       = '0;
        statusBus.statusCellIndex   = '0;
        statusBus.statusCode        = '0;
        statusBus.statusFOFBenabled = '0;
    endtask

    task automatic setRec(input int link, input logic [4:0] idx, input logic [1:0] code,
                          input logic en);
        statusBus.statusValid[link]             = 1'b1;
        statusBus.statusCellIndex[link*CIW +: CIW] = idx;
        statusBus.statusCode[link*2 +: 2]       = code;
        statusBus.statusFOFBenabled[link]       = en;
    endtask

    task automatic writeCfg(input logic [5:0] cells, input logic [7:0] tmo);
        cfgWrite     = 1'b1;
        cfgCellCount = cells;
        cfgTimeoutUs = tmo;
        tick();
        cfgWrite     = 1'b0;
    endtask

    task automatic faStrobe();
        clearStatus();
        statusBus.FAstrobe = 1'b1;
        tick();
        statusBus.FAstrobe = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        sysReset      = 1'b1;
        cfgWrite      = 1'b0;
        cfgCellCount  = '0;
        cfgTimeoutUs  = '0;
        errCountClear = 1'b0;
        clearStatus();
        tick();
        tick();
        check("rst_active", 64'(readoutActive), 64'(0));
        check("rst_valid", 64'(readoutValid), 64'(0));
        check("rst_seqno", 64'(seqno), 64'(0));
        check("rst_errcnt", 64'(linkErrorCount), 64'(0));
        check("rst_bitmap", 64'(fofbBitmapAll), 64'(0));
        sysReset = 1'b0;
        tick();

        // Four cells over four cycles, all FOFB enabled
        writeCfg(6'd4, 8'd0);
        faStrobe();
        check("t1_active", 64'(readoutActive), 64'(1));
        setRec(0, 5'd0, 2'd0, 1'b1); tick(); clearStatus();
        setRec(1, 5'd1, 2'd0, 1'b1); tick(); clearStatus();
        setRec(0, 5'd2, 2'd0, 1'b1); tick(); clearStatus();
        setRec(1, 5'd3, 2'd0, 1'b1); tick(); clearStatus();
        check("t1_bitmap", 64'(fofbBitmapAll), 64'h0F);
        check("t1_valid_early", 64'(readoutValid), 64'(0));
        tick();
        check("t1_valid", 64'(readoutValid), 64'(1));
        check("t1_fofben", 64'(fofbEnabled), 64'(1));
        check("t1_seqno", 64'(seqno), 64'(1));
        check("t1_active_off", 64'(readoutActive), 64'(0));
        check("t1_time", 64'(readoutTime), 64'(0));
        check("t1_bitmap_en", 64'(fofbBitmapEnabled), 64'h0F);

        // Duplicate index on both links in one cycle counts once
        faStrobe();
        check("t2_snapshot", 64'(bitmapAllSnapshot), 64'h0F);
        check("t2_snap_en", 64'(bitmapEnSnapshot), 64'h0F);
        check("t2_cleared", 64'(fofbBitmapAll), 64'(0));
        setRec(0, 5'd2, 2'd0, 1'b1); setRec(1, 5'd2, 2'd0, 1'b1); tick(); clearStatus();
        check("t2_dup_bitmap", 64'(fofbBitmapAll), 64'h04);
        setRec(0, 5'd0, 2'd0, 1'b1); setRec(1, 5'd1, 2'd0, 1'b1); tick(); clearStatus();
        tick();
        check("t2_no_early_valid", 64'(readoutValid), 64'(0));
        setRec(0, 5'd3, 2'd0, 1'b0); tick(); clearStatus();
        tick();
        check("t2_valid", 64'(readoutValid), 64'(1));
        check("t2_fofben", 64'(fofbEnabled), 64'(0));
        check("t2_bitmap_en", 64'(fofbBitmapEnabled), 64'h07);
        check("t2_seqno", 64'(seqno), 64'(2));
        setRec(0, 5'd1, 2'd0, 1'b0); tick(); clearStatus();
        check("t2_idle_hold", 64'(fofbBitmapAll), 64'h0F);
`ifdef FOFB_TRACKER_LATE_COUNT_EN
        check("t2_late", 64'(lateCount), 64'(1));
`endif

        // Timeout at 5 us with 2 of 3 cells
        writeCfg(6'd3, 8'd5);
        faStrobe();
        n = 0;
        for (int k = 1; k <= 600; k++) begin
            clearStatus();
            if (k == 1) setRec(0, 5'd0, 2'd0, 1'b1);
            else if (k == 2) setRec(1, 5'd1, 2'd0, 1'b1);
            tick();
            if (readTimeout) begin
                n = k;
                break;
            end
        end
        clearStatus();
        check("t3_timeout_cycle", 64'(n), 64'(501));
        check("t3_strobe", 64'(timeoutStrobe), 64'(1));
        check("t3_time", 64'(readoutTime), 64'(5));
        check("t3_fofben", 64'(fofbEnabled), 64'(0));
        check("t3_valid", 64'(readoutValid), 64'(0));
        check("t3_active", 64'(readoutActive), 64'(0));
        check("t3_bitmap", 64'(fofbBitmapAll), 64'h03);
        tick();
        check("t3_strobe_pulse", 64'(timeoutStrobe), 64'(0));
        check("t3_timeout_hold", 64'(readTimeout), 64'(1));
        check("t3_seqno", 64'(seqno), 64'(2));

        // Link1 error saturation, then out-of-range index
        setRec(1, 5'd0, 2'd2, 1'b0);
        for (int k = 0; k < 300; k++) tick();
        clearStatus();
        check("t4_err1_sat", 64'(linkErrorCount[15:8]), 64'(255));
        check("t4_err0", 64'(linkErrorCount[7:0]), 64'(0));
        writeCfg(6'd4, 8'd0);
        faStrobe();
        setRec(0, 5'd7, 2'd0, 1'b1); setRec(1, 5'd7, 2'd0, 1'b1); tick(); clearStatus();
        check("t4_range_bitmap", 64'(fofbBitmapAll), 64'(0));
        check("t4_err1_hold", 64'(linkErrorCount[15:8]), 64'(255));
        check("t4_err0_inc", 64'(linkErrorCount[7:0]), 64'(1));
        errCountClear = 1'b1;
        setRec(0, 5'd0, 2'd1, 1'b0); tick(); clearStatus();
        errCountClear = 1'b0;
        check("t4_clear_wins", 64'(linkErrorCount), 64'(0));
`ifdef FOFB_TRACKER_LATE_COUNT_EN
        check("t4_late_clear", 64'(lateCount), 64'(0));
`endif

        // Mid-window config write only applies from the next FA cycle
        writeCfg(6'd2, 8'd0);
        setRec(0, 5'd0, 2'd0, 1'b1); setRec(1, 5'd1, 2'd0, 1'b1); tick(); clearStatus();
        tick();
        check("t5_old_count", 64'(readoutValid), 64'(0));
        setRec(0, 5'd2, 2'd0, 1'b1); setRec(1, 5'd3, 2'd0, 1'b1); tick(); clearStatus();
        tick();
        check("t5_old_valid", 64'(readoutValid), 64'(1));
        check("t5_seqno_a", 64'(seqno), 64'(3));
        faStrobe();
        setRec(0, 5'd0, 2'd0, 1'b1); tick(); clearStatus();
        setRec(1, 5'd1, 2'd0, 1'b1); tick(); clearStatus();
        tick();
        check("t5_new_valid", 64'(readoutValid), 64'(1));
        check("t5_seqno_b", 64'(seqno), 64'(4));
        check("t5_bitmap", 64'(fofbBitmapAll), 64'h03);

        // Asynchronous reset mid-window, then cellCount 0 completes at once
        faStrobe();
        setRec(0, 5'd0, 2'd0, 1'b1); tick(); clearStatus();
        sysReset = 1'b1;
        #2;
        check("t6_rst_active", 64'(readoutActive), 64'(0));
        check("t6_rst_seqno", 64'(seqno), 64'(0));
        check("t6_rst_bitmap", 64'(fofbBitmapAll), 64'(0));
        check("t6_rst_snap", 64'(bitmapAllSnapshot), 64'(0));
        tick();
        sysReset = 1'b0;
        tick();
        faStrobe();
        check("t6_restart", 64'(readoutActive), 64'(1));
        tick();
        check("t6_zero_valid", 64'(readoutValid), 64'(1));
        check("t6_zero_fofben", 64'(fofbEnabled), 64'(1));
        check("t6_zero_seqno", 64'(seqno), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
